// File: rtl/bcd_sevenseg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner for a ten-digit BCD value.
// A snapshot is taken once per scan frame so the displayed digits never tear.
module bcd_sevenseg_scanner #(
  parameter int NUM_DIGITS     = 8,
  parameter int PRESCALE       = 100000,
  parameter bit ACTIVE_LOW_OUT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [39:0]           bcd_in,
  input  logic                  enable,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0]         CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0]         IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW_OUT ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW_OUT ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = ACTIVE_LOW_OUT;
  localparam logic [6:0]            SEG_DASH = 7'h40;

  // Active-high segment pattern, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;
    endcase
    return s;
  endfunction

  function automatic logic overflow_of(input logic [39:0] v);
    logic r;
    r = 1'b0;
    for (int p = 0; p < 10; p++) begin
      if ((p >= NUM_DIGITS) && (v[4*p +: 4] != 4'd0)) begin
        r = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] digit_at(input logic [SW-1:0] v, input logic [IW-1:0] idx);
    logic [3:0] d;
    d = 4'd0;
    for (int p = 0; p < NUM_DIGITS; p++) begin
      if (int'(idx) == p) begin
        d = v[4*p +: 4];
      end
    end
    return d;
  endfunction

  // True when this position and every more-significant shown digit are zero.
  function automatic logic leading_zero(input logic [SW-1:0] v, input logic [IW-1:0] idx);
    logic z;
    z = (idx != '0);
    for (int p = 0; p < NUM_DIGITS; p++) begin
      if ((p >= int'(idx)) && (v[4*p +: 4] != 4'd0)) begin
        z = 1'b0;
      end
    end
    return z;
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         snap_q, snap_d;
  logic                  ovf_q, ovf_d;
  logic                  fd_q, fd_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q;
  logic                  tick_s;
  logic [3:0]            digit_s;
  logic [6:0]            seg_act_s;
  logic [NUM_DIGITS-1:0] an_act_s;

  // Next-state for scan counters and snapshot, plus output pattern for the new index.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    ovf_d     = ovf_q;
    fd_d      = 1'b0;
    an_d      = AN_OFF;
    seg_d     = SEG_OFF;
    tick_s    = (cnt_q == CNT_MAX);
    digit_s   = 4'd0;
    seg_act_s = 7'h00;
    an_act_s  = '0;
    if (enable) begin
      if (tick_s) begin
        cnt_d = '0;
        if (idx_q == IDX_MAX) begin
          idx_d  = '0;
          snap_d = bcd_in[SW-1:0];
          ovf_d  = overflow_of(bcd_in);
          fd_d   = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // Outputs follow the post-edge index and snapshot so a wrap shows fresh data.
      digit_s = digit_at(snap_d, idx_d);
      if (ovf_d) begin
        seg_act_s = SEG_DASH;
      end else if (blank_lz && leading_zero(snap_d, idx_d)) begin
        seg_act_s = 7'h00;
      end else begin
        seg_act_s = seg_decode(digit_s);
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_act_s[i] = (int'(idx_d) == i);
      end
      an_d  = ACTIVE_LOW_OUT ? ~an_act_s : an_act_s;
      seg_d = ACTIVE_LOW_OUT ? ~seg_act_s : seg_act_s;
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
      fd_q   <= 1'b0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      ovf_q  <= ovf_d;
      fd_q   <= fd_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= DP_OFF;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_sevenseg_scanner.sv
// Scoreboard bench: stimulus pushes hand-derived expectations, a negedge monitor compares.
module tb_bcd_sevenseg_scanner;

  localparam int ND = 8;
  localparam int PS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [39:0]   bcd_in;
  logic          enable;
  logic          blank_lz;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_done;
  logic          overflow;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       fd;
    logic       ovf;
    int         tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   t        = 0;

  localparam logic [55:0] T_ZERO   = {8{7'h40}};
  localparam logic [55:0] T_DASH   = {8{7'h3F}};
  localparam logic [55:0] T_B1234  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [55:0] T_N1234  = {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [55:0] T_ZBLANK = {{7{7'h7F}}, 7'h40};

  bcd_sevenseg_scanner #(
    .NUM_DIGITS(ND),
    .PRESCALE(PS),
    .ACTIVE_LOW_OUT(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bcd_in(bcd_in),
    .enable(enable),
    .blank_lz(blank_lz),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_done(frame_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [6:0] s, input logic f, input logic o, input int tag);
    sb_q.push_back('{an: a, seg: s, fd: f, ovf: o, tag: tag});
  endtask

  // One scan edge per iteration; t counts enabled edges since reset release.
  task automatic scan(input int n, input logic [55:0] tbl, input logic ov);
    int idx;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      t++;
      idx = (t / PS) % ND;
      push(~(8'h01 << idx), tbl[7*idx +: 7], ((t % (PS*ND)) == 0), ov, t);
    end
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        m = sb_q.pop_front();
        chk("an", m.tag, an, m.an);
        chk("seg", m.tag, {1'b0, seg}, {1'b0, m.seg});
        chk("frame_done", m.tag, {7'd0, frame_done}, {7'd0, m.fd});
        chk("overflow", m.tag, {7'd0, overflow}, {7'd0, m.ovf});
        chk("dp", m.tag, {7'd0, dp}, 8'd1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    enable   = 1'b1;
    blank_lz = 1'b0;
    bcd_in   = 40'h99_9999_9999;
    #2;
    push(8'hFF, 7'h7F, 1'b0, 1'b0, -1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    t = 0;

    // First frame shows the reset snapshot; wrap captures all 9s (overflow).
    scan(31, T_ZERO, 1'b0);
    scan(2, T_DASH, 1'b1);
    bcd_in   = 40'h00_0000_1234;
    blank_lz = 1'b1;
    scan(30, T_DASH, 1'b1);
    scan(32, T_B1234, 1'b0);
    blank_lz = 1'b0;
    scan(2, T_N1234, 1'b0);
    bcd_in = 40'h0;
    scan(30, T_N1234, 1'b0);
    blank_lz = 1'b1;
    scan(2, T_ZBLANK, 1'b0);
    bcd_in = 40'h01_2345_6789;
    scan(30, T_ZBLANK, 1'b0);
    scan(11, T_DASH, 1'b1);

    // Freeze for 10 edges, then resume from the held count and index.
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      push(8'hFF, 7'h7F, 1'b0, 1'b1, -2);
    end
    enable = 1'b1;
    scan(34, T_DASH, 1'b1);

    // Asynchronous reset mid-frame; checked before any further clock edge.
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(8'hFF, 7'h7F, 1'b0, 1'b0, -3);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    t = 0;
    scan(8, T_ZBLANK, 1'b0);

    repeat (3) @(negedge clk);
    chk("drain", -4, 8'(sb_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
